// File: rtl/rp_pkg.sv
// Shared RP disk emulation definitions: CHS/LSA widths, sequencer state codes, RP06 geometry.
// Latency: n/a (package).
// Backpressure: n/a (package).
package rp_pkg;

    localparam int CYL_W = 10;
    localparam int TRK_W = 6;
    localparam int SEC_W = 6;
    localparam int LSA_W = 21;

    // RP06 pack geometry, used by benches and bring-up configurations
    localparam int RP06_CYL = 815;
    localparam int RP06_TRK = 19;
    localparam int RP06_SEC = 20;

    // Transfer sequencer state encoding
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_CHECK = 3'd1;
    localparam state_t S_START = 3'd2;
    localparam state_t S_CALC  = 3'd3;
    localparam state_t S_REQ   = 3'd4;
    localparam state_t S_INCR  = 3'd5;
    localparam state_t S_DONE  = 3'd6;

    // True when a CHS address lies inside the configured pack geometry
    function automatic logic chs_in_range(
        input logic [CYL_W-1:0] dca,
        input logic [TRK_W-1:0] ta,
        input logic [SEC_W-1:0] sa,
        input logic [CYL_W-1:0] cylnum,
        input logic [TRK_W-1:0] trknum,
        input logic [SEC_W-1:0] secnum
    );
        return (dca < cylnum) && (ta < trknum) && (sa < secnum);
    endfunction

endpackage

// File: rtl/rpxfer_chsinc.sv
// Combinational CHS incrementer: sector, carry into track, carry into cylinder, end-of-pack flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result is valid whenever inputs are.
module rpxfer_chsinc
    import rp_pkg::*;
(
    input  logic [CYL_W-1:0] dca,
    input  logic [TRK_W-1:0] ta,
    input  logic [SEC_W-1:0] sa,
    input  logic [CYL_W-1:0] cylnum,
    input  logic [TRK_W-1:0] trknum,
    input  logic [SEC_W-1:0] secnum,
    output logic [CYL_W-1:0] nxt_dca,
    output logic [TRK_W-1:0] nxt_ta,
    output logic [SEC_W-1:0] nxt_sa,
    output logic             ovf
);

    // One extra bit on each sum so a field at its maximum code still compares correctly
    logic [SEC_W:0] sa_p1;
    logic [TRK_W:0] ta_p1;
    logic [CYL_W:0] dca_p1;
    logic [TRK_W:0] ta_mid;

    // Ripple the +1 through sector, track and cylinder using the geometry limits
    always_comb begin
        sa_p1  = {1'b0, sa} + (SEC_W+1)'(1);
        ta_p1  = {1'b0, ta} + (TRK_W+1)'(1);
        dca_p1 = {1'b0, dca} + (CYL_W+1)'(1);
        nxt_sa  = sa_p1[SEC_W-1:0];
        ta_mid  = {1'b0, ta};
        nxt_dca = dca;
        if (sa_p1 == {1'b0, secnum}) begin
            nxt_sa = '0;
            ta_mid = ta_p1;
        end
        nxt_ta = ta_mid[TRK_W-1:0];
        if (ta_mid == {1'b0, trknum}) begin
            nxt_ta  = '0;
            nxt_dca = dca_p1[CYL_W-1:0];
        end
        // The overflowed cylinder value is kept by the caller, so flag it here
        ovf = ({1'b0, nxt_dca} == {1'b0, cylnum});
    end

endmodule

// File: rtl/rpxfer_seq.sv
// Sector transfer sequencer: walks CHS per sector, runs RPADDR, issues one SD request per sector.
// Latency: GO -> CHECK next cycle -> ADRSTRT or DONE the cycle after; then calc + SD time per sector.
// Backpressure: waits on rpADRBUSY and holds sdREQ until sdACK; GO ignored while busy.
module rpxfer_seq
    import rp_pkg::*;
#(
    parameter int CNTW = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             xferGO,
    input  logic             xferCLR,
    input  logic [CYL_W-1:0] rpCYLNUM,
    input  logic [TRK_W-1:0] rpTRKNUM,
    input  logic [SEC_W-1:0] rpSECNUM,
    input  logic [CYL_W-1:0] xferDCA,
    input  logic [TRK_W-1:0] xferTA,
    input  logic [SEC_W-1:0] xferSA,
    input  logic [CNTW-1:0]  xferCNT,
    output logic [CYL_W-1:0] rpDCA,
    output logic [TRK_W-1:0] rpTA,
    output logic [SEC_W-1:0] rpSA,
    output logic             rpADRSTRT,
    input  logic             rpADRBUSY,
    input  logic [LSA_W-1:0] rpSDLSA,
    output logic             sdREQ,
    output logic [LSA_W-1:0] sdLSA,
    input  logic             sdACK,
    input  logic             sdERR,
    output logic             xferBUSY,
    output logic             xferDONE,
    output logic             xferIAE,
    output logic             xferAOE,
    output logic             xferERR
);

    state_t           state;
    state_t           state_nxt;
    logic [CYL_W-1:0] dca;
    logic [TRK_W-1:0] ta;
    logic [SEC_W-1:0] sa;
    logic [CNTW-1:0]  cnt;
    logic [LSA_W-1:0] lsa;
    logic             iae;
    logic             aoe;
    logic             err;

    logic [CYL_W-1:0] inc_dca;
    logic [TRK_W-1:0] inc_ta;
    logic [SEC_W-1:0] inc_sa;
    logic             inc_ovf;

    logic             cnt_zero;
    logic             addr_ok;
    logic             load;
    logic             ack_ok;
    logic             ack_err;
    logic             calc_done;

    rpxfer_chsinc u_chsinc (
        .dca     (dca),
        .ta      (ta),
        .sa      (sa),
        .cylnum  (rpCYLNUM),
        .trknum  (rpTRKNUM),
        .secnum  (rpSECNUM),
        .nxt_dca (inc_dca),
        .nxt_ta  (inc_ta),
        .nxt_sa  (inc_sa),
        .ovf     (inc_ovf)
    );

    // Shared qualifiers; every state-advancing event is masked by an abort
    always_comb begin
        cnt_zero  = (cnt == '0);
        addr_ok   = chs_in_range(dca, ta, sa, rpCYLNUM, rpTRKNUM, rpSECNUM);
        load      = !xferCLR && (state == S_IDLE) && xferGO;
        ack_ok    = !xferCLR && (state == S_REQ) && sdACK && !sdERR;
        ack_err   = !xferCLR && (state == S_REQ) && sdACK && sdERR;
        calc_done = !xferCLR && (state == S_CALC) && !rpADRBUSY;
    end

    // Next-state decode; abort overrides everything and returns to IDLE without DONE
    always_comb begin
        state_nxt = state;
        if (xferCLR) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (xferGO) state_nxt = S_CHECK;
                S_CHECK: state_nxt = (cnt_zero || !addr_ok) ? S_DONE : S_START;
                S_START: state_nxt = S_CALC;
                S_CALC:  if (!rpADRBUSY) state_nxt = S_REQ;
                S_REQ:   if (sdACK) state_nxt = sdERR ? S_DONE : S_INCR;
                S_INCR:  state_nxt = (cnt_zero || inc_ovf) ? S_DONE : S_START;
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // CHS address: loaded on GO, stepped in INCR, otherwise held (including across abort)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dca <= '0;
            ta  <= '0;
            sa  <= '0;
        end else if (load) begin
            dca <= xferDCA;
            ta  <= xferTA;
            sa  <= xferSA;
        end else if (!xferCLR && (state == S_INCR)) begin
            dca <= inc_dca;
            ta  <= inc_ta;
            sa  <= inc_sa;
        end
    end

    // Remaining sector count, decremented on each successful SD completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         cnt <= '0;
        else if (load)   cnt <= xferCNT;
        else if (ack_ok) cnt <= cnt - CNTW'(1);
    end

    // LSA captured once RPADDR finishes, held stable for the whole request
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            lsa <= '0;
        else if (calc_done) lsa <= rpSDLSA;
    end

    // Sticky error flags: cleared on GO or abort, set by the failing condition
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iae <= 1'b0;
            aoe <= 1'b0;
            err <= 1'b0;
        end else if (xferCLR || load) begin
            iae <= 1'b0;
            aoe <= 1'b0;
            err <= 1'b0;
        end else begin
            if ((state == S_CHECK) && !cnt_zero && !addr_ok) iae <= 1'b1;
            if ((state == S_INCR) && !cnt_zero && inc_ovf)   aoe <= 1'b1;
            if (ack_err)                                     err <= 1'b1;
        end
    end

    // Outputs are registers or pure state decodes
    assign rpDCA     = dca;
    assign rpTA      = ta;
    assign rpSA      = sa;
    assign sdLSA     = lsa;
    assign rpADRSTRT = (state == S_START);
    assign sdREQ     = (state == S_REQ);
    assign xferBUSY  = (state != S_IDLE);
    assign xferDONE  = (state == S_DONE);
    assign xferIAE   = iae;
    assign xferAOE   = aoe;
    assign xferERR   = err;

endmodule
